// File: rtl/deint_pkg.sv
// deint_pkg: shared constants, FSM state types and the frame-length check
// used by the block deinterleaver.
package deint_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 12;
    localparam int COLS   = 8;
    localparam int CW     = $clog2(COLS);

    typedef enum logic {W_IDLE, W_FILL}  wfsm_t;
    typedef enum logic {R_IDLE, R_DRAIN} rfsm_t;

    function automatic logic len_ok(input logic [ADDR_W-1:0] len, input int max_len);
        return len != '0 && len[CW-1:0] == '0 && int'(len) <= max_len;
    endfunction
endpackage

// File: rtl/deint_dpram.sv
// deint_dpram: simple dual-port RAM, one write port and one registered read port;
// the address MSB selects the ping-pong bank.
module deint_dpram #(
    parameter int DATA_W = 8,
    parameter int AW     = 13
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/multiplexed_deinterleaver.sv
// multiplexed_deinterleaver: writes column-ordered bytes to row-major addresses in one
// of two banks and drains full banks in address order through a 2-entry skid buffer.
module multiplexed_deinterleaver #(
    parameter int DATA_W  = deint_pkg::DATA_W,
    parameter int MAX_LEN = 2712,
    parameter int ADDR_W  = deint_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] length,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              length_err
);
    import deint_pkg::*;

    localparam int RW = ADDR_W - CW;

    wfsm_t             r_wst, w_wst_nx;
    rfsm_t             r_rst, w_rst_nx;
    logic [1:0]        r_full;
    logic              r_wbank, r_rbank;
    logic [ADDR_W-1:0] r_len [2];
    logic [RW-1:0]     r_row, r_rows, w_rows;
    logic [CW-1:0]     r_col;
    logic [ADDR_W-1:0] r_raddr;
    logic              w_len_ok, w_in_fire, w_row_wrap, w_wlast, w_rd, w_rd_last;
    logic [DATA_W-1:0] w_q;
    logic              r_pend, r_pend_last;
    logic [DATA_W-1:0] r_fd [2];
    logic [1:0]        r_fl;
    logic              r_fwp, r_frp;
    logic [1:0]        r_cnt;
    logic              w_pop, w_push, w_fpop;

    assign w_len_ok   = len_ok(length, MAX_LEN);
    assign in_ready   = !reset && !r_full[r_wbank] && (r_wst == W_FILL || w_len_ok);
    assign length_err = !reset && r_wst == W_IDLE && !w_len_ok;
    assign w_in_fire  = in_valid && in_ready;
    assign w_rows     = (r_wst == W_IDLE) ? length[ADDR_W-1:CW] : r_rows;
    assign w_row_wrap = r_row + RW'(1) == w_rows;
    assign w_wlast    = w_row_wrap && r_col == CW'(COLS - 1);

    // Read is issued only if, even with no pop next cycle, its byte still fits in the skid buffer.
    assign w_pop     = out_valid && out_ready;
    assign w_fpop    = r_cnt != 2'd0 && out_ready;
    assign w_push    = r_pend && !(r_cnt == 2'd0 && out_ready);
    assign w_rd      = (r_rst == R_DRAIN || r_full[r_rbank]) &&
                       ({1'b0, r_cnt} + {2'b0, r_pend} - {2'b0, w_pop}) <= 3'd1;
    assign w_rd_last = w_rd && r_raddr == r_len[r_rbank] - ADDR_W'(1);

    // An empty buffer passes the RAM output straight through, saving a cycle of latency.
    assign out_valid = r_cnt != 2'd0 || r_pend;
    assign data_out  = (r_cnt != 2'd0) ? r_fd[r_frp] : (r_pend ? w_q : '0);
    assign out_last  = (r_cnt != 2'd0) ? r_fl[r_frp] : r_pend && r_pend_last;

    always_comb begin
        w_wst_nx = r_wst;
        if (w_in_fire) w_wst_nx = w_wlast ? W_IDLE : W_FILL;
    end

    always_comb begin
        w_rst_nx = r_rst;
        if (w_rd) w_rst_nx = w_rd_last ? R_IDLE : R_DRAIN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wst       <= W_IDLE;
            r_rst       <= R_IDLE;
            r_full      <= '0;
            r_wbank     <= 1'b0;
            r_rbank     <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_rows      <= '0;
            r_raddr     <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_fwp       <= 1'b0;
            r_frp       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_wst       <= w_wst_nx;
            r_rst       <= w_rst_nx;
            r_pend      <= w_rd;
            r_pend_last <= w_rd_last;
            r_cnt       <= r_cnt + {1'b0, w_push} - {1'b0, w_fpop};
            if (w_push) r_fwp <= !r_fwp;
            if (w_fpop) r_frp <= !r_frp;
            if (w_in_fire) begin
                if (r_wst == W_IDLE) r_rows <= w_rows;
                r_row <= w_row_wrap ? '0 : r_row + RW'(1);
                if (w_row_wrap) r_col <= r_col + CW'(1);
                if (w_wlast) begin
                    r_full[r_wbank] <= 1'b1;
                    r_wbank         <= !r_wbank;
                end
            end
            if (w_rd) r_raddr <= w_rd_last ? '0 : r_raddr + ADDR_W'(1);
            if (w_rd_last) begin
                r_full[r_rbank] <= 1'b0;
                r_rbank         <= !r_rbank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire && r_wst == W_IDLE) r_len[r_wbank] <= length;
        if (w_push) begin
            r_fd[r_fwp] <= w_q;
            r_fl[r_fwp] <= r_pend_last;
        end
    end

    deint_dpram #(.DATA_W(DATA_W), .AW(ADDR_W + 1)) u_ram (
        .clk     (clk),
        .i_we    (w_in_fire),
        .i_waddr ({r_wbank, r_row, r_col}),
        .i_wdata (data_in),
        .i_raddr ({r_rbank, r_raddr}),
        .o_rdata (w_q)
    );
endmodule
